// File: rtl/execute.sv
// Execute stage: operand forwarding, integer ALU and the EX/MEM pipeline register.
// Forwarding reads the stage's own registered outputs (EX/MEM) and the
// write-back bus, so a dependent instruction can issue back-to-back.
module execute #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      fwd_raddr1_i,
    input  logic [4:0]      fwd_raddr2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic [2:0]      opfunc3_i,
    input  logic [2:0]      optype_i,
    input  logic            shiftsel_i,
    input  logic            addsubsel_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [4:0]      wb_rd_addr_i,
    input  logic            wb_rd_we_i,
    input  logic [XLEN-1:0] wb_rd_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic [2:0]      mem_func3_o
);

    localparam logic [2:0] OPT_R     = 3'b000;
    localparam logic [2:0] OPT_I     = 3'b001;
    localparam logic [2:0] OPT_LOAD  = 3'b010;
    localparam logic [2:0] OPT_STORE = 3'b011;
    localparam logic [2:0] OPT_LUI   = 3'b100;
    localparam logic [2:0] OPT_AUIPC = 3'b101;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_we_q, rd_we_d;
    logic            mem_re_q, mem_re_d;
    logic            mem_we_q, mem_we_d;
    logic [2:0]      mem_func3_q, mem_func3_d;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] result;
    logic            is_bubble;
    logic            exmem_fwd_ok;
    logic            wb_fwd_ok;

    // Operand forwarding: EX/MEM wins over WB; loads in EX/MEM have no data yet; x0 never matches.
    always_comb begin
        exmem_fwd_ok = rd_we_q && !mem_re_q && (rd_addr_q != 5'd0);
        wb_fwd_ok    = wb_rd_we_i && (wb_rd_addr_i != 5'd0);

        op_a = rs1_i;
        if (exmem_fwd_ok && (rd_addr_q == fwd_raddr1_i)) begin
            op_a = alu_result_q;
        end else if (wb_fwd_ok && (wb_rd_addr_i == fwd_raddr1_i)) begin
            op_a = wb_rd_data_i;
        end

        op_b = rs2_i;
        if (exmem_fwd_ok && (rd_addr_q == fwd_raddr2_i)) begin
            op_b = alu_result_q;
        end else if (wb_fwd_ok && (wb_rd_addr_i == fwd_raddr2_i)) begin
            op_b = wb_rd_data_i;
        end

        alu_b = (optype_i == OPT_R) ? op_b : imm_i;
        shamt = alu_b[4:0];
    end

    // ALU: result selection by instruction type and funct3.
    always_comb begin
        result    = '0;
        is_bubble = 1'b0;
        case (optype_i)
            OPT_R, OPT_I: begin
                case (opfunc3_i)
                    3'b000: result = (addsubsel_i && (optype_i == OPT_R)) ? (op_a - alu_b) : (op_a + alu_b);
                    3'b001: result = op_a << shamt;
                    3'b010: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
                    3'b011: result = {{(XLEN-1){1'b0}}, (op_a < alu_b)};
                    3'b100: result = op_a ^ alu_b;
                    3'b101: result = shiftsel_i ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
                    3'b110: result = op_a | alu_b;
                    default: result = op_a & alu_b;
                endcase
            end
            OPT_LOAD, OPT_STORE: result = op_a + imm_i;
            OPT_LUI:             result = imm_i;
            OPT_AUIPC:           result = pc_i + imm_i;
            default: begin
                result    = '0;
                is_bubble = 1'b1;
            end
        endcase
    end

    // EX/MEM next state: flush clears, stall holds, otherwise capture this instruction.
    always_comb begin
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        mem_func3_d  = mem_func3_q;
        if (flush_i) begin
            alu_result_d = '0;
            store_data_d = '0;
            rd_addr_d    = '0;
            rd_we_d      = 1'b0;
            mem_re_d     = 1'b0;
            mem_we_d     = 1'b0;
            mem_func3_d  = '0;
        end else if (!stall_i) begin
            alu_result_d = result;
            store_data_d = op_b;
            rd_addr_d    = rd_addr_i;
            rd_we_d      = rd_we_i && !is_bubble;
            mem_re_d     = mem_re_i && !is_bubble;
            mem_we_d     = mem_we_i && !is_bubble;
            mem_func3_d  = opfunc3_i;
        end
    end

    // EX/MEM register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_func3_q  <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_func3_q  <= mem_func3_d;
        end
    end

    assign alu_result_o = alu_result_q;
    assign store_data_o = store_data_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;
    assign mem_re_o     = mem_re_q;
    assign mem_we_o     = mem_we_q;
    assign mem_func3_o  = mem_func3_q;

endmodule
